reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Writeback arbiter and scoreboard for the 16 x 32-bit register file. It shares the register file's single write port between two writeback requesters: A, the ALU result path, and B, the memory-load path. It also tracks which registers have a write outstanding, so the issue stage stalls on RAW and WAW hazards. It sits between the execute/memory stages and the register file, and drives the file's `reg_wr`, `Rd` and `DI` inputs directly.

## Interface
Parameters: none. Register count (16), register index width (4) and data width (32) are fixed by the register file.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_valid`  in  1  requester A (ALU) has a result to write.
- `a_rd`  in  4  requester A destination register.
- `a_data`  in  32  requester A write data.
- `a_ready`  out  1  A is granted this cycle (combinational).
- `b_valid`  in  1  requester B (load) has a result to write.
- `b_rd`  in  4  requester B destination register.
- `b_data`  in  32  requester B write data.
- `b_ready`  out  1  B is granted this cycle (combinational).
- `iss_valid`  in  1  issue stage presents an instruction.
- `iss_wr`  in  1  issued instruction writes `iss_rd`.
- `iss_rd`, `iss_rs1`, `iss_rs2`  in  4 each  destination and source indices.
- `iss_stall`  out  1  issue must hold this cycle (combinational).
- `reg_rd`  out  1  register-file read enable; equals `iss_valid`.
- `reg_wr`  out  1  register-file write enable (registered).
- `Rd`  out  4  register-file write index (registered).
- `DI`  out  32  register-file write data (registered).

## Operation
- Handshake:
  - A transfer occurs on `x_valid & x_ready` at a rising edge.
  - `x_ready` depends only on both valids and the round-robin pointer `rr`; it never depends on ready.
  - Requesters hold `valid`, `rd` and `data` stable until the transfer.
- Arbitration:
  - At most one grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: `rr=0` grants A, `rr=1` grants B.
  - After every transfer, `rr` points to the non-granted requester.
  - No grant: `rr` holds.
- Write-port register:
  - On a transfer, `reg_wr<=1`, `Rd<=granted rd`, `DI<=granted data`.
  - Otherwise `reg_wr<=0`, and `Rd`/`DI` hold their values.
- Scoreboard: 16-bit `pending` vector.
  - `iss_stall = iss_valid & (pending[iss_rs1] | pending[iss_rs2] | (iss_wr & pending[iss_rd]))`.
  - Set: `pending[iss_rd]<=1` when `iss_valid & iss_wr & ~iss_stall`.
  - Clear: `pending[Rd]<=0` at the rising edge ending any cycle with `reg_wr=1`.
  - Set and clear of the same index on the same edge: set wins.
  - A write to a non-pending register is legal and leaves `pending` unchanged.
- Ordering:
  - The WAW stall guarantees at most one outstanding write per register.
  - If both requesters nevertheless target the same rd, the writes are not merged; both are written in round-robin order.
- All 16 registers are ordinary registers; none is hardwired to zero.
- Reset values: `pending=0`, `rr=0`, `reg_wr=0`, `Rd=0`, `DI=0`.
  - Reset mid-operation discards any registered write and all pending bits.
  - Requesters must re-present their data after reset.

## Timing
- Transfer at rising edge T:
  - `reg_wr/Rd/DI` are valid from T to T+1.
  - The register file commits the write at the falling edge inside that cycle.
  - `pending[Rd]` clears at T+1.
- A dependent instruction stalled on that register:
  - Sees `iss_stall=0` in cycle T+1.
  - Its combinational reads return the new value in that cycle.
- Throughput is one write per cycle. Under continuous contention each requester gets one grant every 2 cycles.
- Issue-to-stall: a register set pending at edge E stalls readers from cycle E onward.

## Test plan
- Reset, then idle:
  - `reg_wr=0`, `Rd=0`, `DI=0`, `iss_stall=0` for any sources.
  - `a_ready=b_ready=0` while both valids are low.
- Single write, A only, `a_rd=5`, `a_data=32'hDEADBEEF`:
  - `a_ready=1` in the same cycle.
  - Next cycle `reg_wr=1`, `Rd=5`, `DI=32'hDEADBEEF`.
  - The cycle after, `reg_wr=0` and register 5 reads `DEADBEEF`.
- Contention, A and B both valid for 4 cycles:
  - Grants alternate A, B, A, B.
  - `reg_wr` stays high from cycle 2 through 5 with the matching `Rd/DI`.
- RAW hazard:
  - Issue with `iss_wr=1`, `iss_rd=3`; next instruction `iss_rs1=3` gets `iss_stall=1`.
  - B then writes r3 with `32'h1234`; the stall drops in the cycle after `reg_wr=1`, and the read returns `0x1234`.
- WAW plus simultaneous set/clear:
  - Issue `rd=7` stalls while r7 is pending.
  - An issue of `rd=7` on the same edge the r7 write completes leaves `pending[7]=1`.
- Async reset mid-stream:
  - Assert `rst` between edges while `reg_wr=1` and `pending=16'h00F0`.
  - Outputs go to 0 immediately and `pending=0`.
  - First grant after release goes to A.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//
// Writeback arbiter and scoreboard for the 16 x 32-bit register file.
// Two writeback requesters (A = ALU result path, B = memory-load path)
// share the register file's single write port under round-robin
// arbitration. A pending-write scoreboard stalls the issue stage on RAW
// and WAW hazards against registers that still have a write in flight.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   a_valid/a_rd/a_data       requester A write request
//   a_ready                   A granted this cycle (combinational)
//   b_valid/b_rd/b_data       requester B write request
//   b_ready                   B granted this cycle (combinational)
//   iss_valid/iss_wr          issue stage instruction present / writes iss_rd
//   iss_rd/iss_rs1/iss_rs2    destination and source register indices
//   iss_stall                 issue must hold this cycle (combinational)
//   reg_rd                    register-file read enable (= iss_valid)
//   reg_wr/Rd/DI              registered register-file write port
// ---------------------------------------------------------------------------
module reg_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [3:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic        iss_wr,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  iss_rs1,
  input  logic [3:0]  iss_rs2,
  output logic        iss_stall,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [3:0]  Rd,
  output logic [31:0] DI
);

  // rr_reg = 0: A wins a tie; rr_reg = 1: B wins a tie.
  logic        rr_reg;
  logic [15:0] pending_reg;
  logic [15:0] pending_next;
  logic        grant_a;
  logic        grant_b;
  logic        iss_set;

  // Grants depend only on the valids and the pointer, never on ready,
  // so there is no combinational loop through the requesters.
  assign grant_a = a_valid & (~b_valid | ~rr_reg);
  assign grant_b = b_valid & (~a_valid |  rr_reg);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // A source or destination with a write still in flight blocks issue.
  assign iss_stall = iss_valid & (pending_reg[iss_rs1] | pending_reg[iss_rs2] |
                                  (iss_wr & pending_reg[iss_rd]));
  assign iss_set   = iss_valid & iss_wr & ~iss_stall;
  assign reg_rd    = iss_valid;

  // Per-register scoreboard update. The clear comes from the write that is
  // on the port during this cycle; a new issue to the same index on the
  // same edge re-marks it pending, so the set term dominates.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pending
      assign pending_next[gi] = (iss_set & (iss_rd == 4'(gi))) |
                                (pending_reg[gi] & ~(reg_wr & (Rd == 4'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg      <= 1'b0;
      pending_reg <= 16'h0000;
      reg_wr      <= 1'b0;
      Rd          <= 4'h0;
      DI          <= 32'h0000_0000;
    end else begin
      pending_reg <= pending_next;
      reg_wr      <= grant_a | grant_b;
      // After a transfer the pointer favours the requester that lost;
      // with no transfer the pointer and the write index/data hold.
      if (grant_a) begin
        rr_reg <= 1'b1;
        Rd     <= a_rd;
        DI     <= a_data;
      end else if (grant_b) begin
        rr_reg <= 1'b0;
        Rd     <= b_rd;
        DI     <= b_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Self-checking bench for reg_wb_arbiter: a directed vector table walking
// through idle, single write, contention, RAW, WAW and set/clear collision,
// a hand-written asynchronous reset sequence, and a randomized phase
// checked against a behavioural model of the arbiter and scoreboard.
// A small register-file model captures the write port on falling edges.
// ---------------------------------------------------------------------------
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, b_valid, iss_valid, iss_wr;
  logic [3:0]  a_rd, b_rd, iss_rd, iss_rs1, iss_rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, iss_stall, reg_rd, reg_wr;
  logic [3:0]  Rd;
  logic [31:0] DI;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .Rd(Rd), .DI(DI)
  );

  // Register file: commits on the falling edge inside the write cycle.
  logic [31:0] rf [16];
  always @(negedge clk) if (reg_wr) rf[Rd] <= DI;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct packed {
    logic        av;  logic [3:0] ard; logic [31:0] adat;
    logic        bv;  logic [3:0] brd; logic [31:0] bdat;
    logic        iv;  logic iw; logic [3:0] ird; logic [3:0] irs1; logic [3:0] irs2;
    logic        ea;  logic eb; logic es;
    logic        ew;  logic [3:0] erd; logic [31:0] edi;
    logic        rfc; logic [3:0] rfi; logic [31:0] rfv;
  } vec_t;

  function automatic vec_t mk(input int av, input int ard, input logic [31:0] adat,
                              input int bv, input int brd, input logic [31:0] bdat,
                              input int iv, input int iw, input int ird,
                              input int rs1, input int rs2,
                              input int ea, input int eb, input int es,
                              input int ew, input int erd, input logic [31:0] edi,
                              input int rfc, input int rfi, input logic [31:0] rfv);
    vec_t v;
    v.av = 1'(av);  v.ard = 4'(ard); v.adat = adat;
    v.bv = 1'(bv);  v.brd = 4'(brd); v.bdat = bdat;
    v.iv = 1'(iv);  v.iw = 1'(iw);   v.ird = 4'(ird);
    v.irs1 = 4'(rs1); v.irs2 = 4'(rs2);
    v.ea = 1'(ea);  v.eb = 1'(eb);   v.es = 1'(es);
    v.ew = 1'(ew);  v.erd = 4'(erd); v.edi = edi;
    v.rfc = 1'(rfc); v.rfi = 4'(rfi); v.rfv = rfv;
    return v;
  endfunction

  // Called at posedge+1: drive, check combinational outputs at +2,
  // then check the registered write port one step after the next edge.
  task automatic apply(input vec_t v, input string tag);
    a_valid = v.av; a_rd = v.ard; a_data = v.adat;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bdat;
    iss_valid = v.iv; iss_wr = v.iw; iss_rd = v.ird;
    iss_rs1 = v.irs1; iss_rs2 = v.irs2;
    #1;
    chk({tag, " a_ready"},   32'(a_ready),   32'(v.ea));
    chk({tag, " b_ready"},   32'(b_ready),   32'(v.eb));
    chk({tag, " iss_stall"}, 32'(iss_stall), 32'(v.es));
    chk({tag, " reg_rd"},    32'(reg_rd),    32'(v.iv));
    if (v.rfc) chk({tag, " rf"}, rf[v.rfi], v.rfv);
    @(posedge clk); #1;
    chk({tag, " reg_wr"}, 32'(reg_wr), 32'(v.ew));
    chk({tag, " Rd"},     32'(Rd),     32'(v.erd));
    chk({tag, " DI"},     DI,          v.edi);
    $display("%s: a_rdy=%0b b_rdy=%0b stall=%0b -> wr=%0b Rd=%0d DI=%h",
             tag, a_ready, b_ready, iss_stall, reg_wr, Rd, DI);
  endtask

  task automatic clear_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_wr = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Behavioural model state for the randomized phase.
  bit          pend_m [16];
  bit          b_first;          // B wins the next tie
  logic        exp_wr;
  logic [3:0]  exp_rd;
  logic [31:0] exp_di;

  // Prefer destinations that are pending so the scoreboard keeps draining.
  function automatic logic [3:0] pick_rd();
    int s = int'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0)
      for (int k = 0; k < 16; k++)
        if (pend_m[(s + k) % 16]) return 4'((s + k) % 16);
    return 4'(s);
  endfunction

  vec_t tbl [19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- directed table ----------------
    //             A:v rd data        B:v rd data        iss:v wr rd rs1 rs2  exp:ar br st  wr Rd DI            rf chk
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 0, 15,      0, 0, 0,   0, 0, 0,             0, 0, 0);
    tbl[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 0, 0,       1, 0, 0,   1, 5, 32'hDEADBEEF,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 5, 5,       0, 0, 0,   0, 5, 32'hDEADBEEF,  0, 0, 0);
    tbl[3]  = mk(0, 0, 0,            1, 1, 32'h1111,    0, 0, 0, 0, 0,       0, 1, 0,   1, 1, 32'h1111,      1, 5, 32'hDEADBEEF);
    tbl[4]  = mk(1, 8, 32'hA0,       1, 10, 32'hB0,     0, 0, 0, 0, 0,       1, 0, 0,   1, 8, 32'hA0,        0, 0, 0);
    tbl[5]  = mk(1, 9, 32'hA1,       1, 10, 32'hB0,     0, 0, 0, 0, 0,       0, 1, 0,   1, 10, 32'hB0,       0, 0, 0);
    tbl[6]  = mk(1, 9, 32'hA1,       1, 11, 32'hB1,     0, 0, 0, 0, 0,       1, 0, 0,   1, 9, 32'hA1,        0, 0, 0);
    tbl[7]  = mk(1, 12, 32'hA2,      1, 11, 32'hB1,     0, 0, 0, 0, 0,       0, 1, 0,   1, 11, 32'hB1,       0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0, 0,       0, 0, 0,   0, 11, 32'hB1,       1, 9, 32'hA1);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,           1, 1, 3, 0, 0,       0, 0, 0,   0, 11, 32'hB1,       0, 0, 0);
    tbl[10] = mk(0, 0, 0,            1, 3, 32'h1234,    1, 0, 0, 3, 0,       0, 1, 1,   1, 3, 32'h1234,      0, 0, 0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 3, 0,       0, 0, 1,   0, 3, 32'h1234,      0, 0, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 3, 0,       0, 0, 0,   0, 3, 32'h1234,      1, 3, 32'h1234);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,           1, 1, 7, 0, 0,       0, 0, 0,   0, 3, 32'h1234,      0, 0, 0);
    tbl[14] = mk(1, 7, 32'h7777,     0, 0, 0,           1, 1, 7, 0, 0,       1, 0, 1,   1, 7, 32'h7777,      0, 0, 0);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,           1, 1, 7, 0, 0,       0, 0, 1,   0, 7, 32'h7777,      0, 0, 0);
    tbl[16] = mk(1, 7, 32'h8888,     0, 0, 0,           1, 0, 0, 7, 7,       1, 0, 0,   1, 7, 32'h8888,      1, 7, 32'h7777);
    tbl[17] = mk(0, 0, 0,            0, 0, 0,           1, 1, 7, 0, 0,       0, 0, 0,   0, 7, 32'h8888,      0, 0, 0);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 7, 0,       0, 0, 1,   0, 7, 32'h8888,      1, 7, 32'h8888);

    do_reset();
    chk("reset reg_wr", 32'(reg_wr), 32'd0);
    chk("reset Rd",     32'(Rd),     32'd0);
    chk("reset DI",     DI,          32'd0);
    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // ---------------- asynchronous reset mid-stream ----------------
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq0");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq1");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_seq3");
    // A writes r2 (rr moves to B); r4 is pending so the probe stalls.
    apply(mk(1, 2, 32'hCAFE0002, 0, 0, 0, 1, 0, 0, 4, 0, 1, 0, 1, 1, 2, 32'hCAFE0002, 0, 0, 0), "rst_seq4");
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    chk("async reg_wr", 32'(reg_wr), 32'd0);
    chk("async Rd",     32'(Rd),     32'd0);
    chk("async DI",     DI,          32'd0);
    iss_valid = 1; iss_rs1 = 5; iss_rs2 = 6;
    #1 chk("async stall r5 r6", 32'(iss_stall), 32'd0);
    iss_rs1 = 7; iss_rs2 = 4;
    #1 chk("async stall r7 r4", 32'(iss_stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    $display("rst_seq: async reset applied and released");
    apply(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 1, 0, 0, 4, 7, 1, 0, 0, 1, 1, 32'hA1, 0, 0, 0), "rst_seq5");

    // ---------------- randomized phase vs behavioural model ----------------
    do_reset();
    begin
      bit          av = 0, bv = 0;
      logic [3:0]  ar = 0, br = 0;
      logic [31:0] ad = 0, bd = 0;
      for (int k = 0; k < 16; k++) pend_m[k] = 0;
      b_first = 0; exp_wr = 0; exp_rd = 0; exp_di = 0;
      for (int c = 0; c < 400; c++) begin
        bit         iv, iw, stall_m;
        logic [3:0] ird, rs1, rs2;
        int         winner;   // 0 none, 1 A, 2 B
        if (!av && $urandom_range(0, 1) == 1) begin av = 1; ar = pick_rd(); ad = $urandom; end
        if (!bv && $urandom_range(0, 1) == 1) begin bv = 1; br = pick_rd(); bd = $urandom; end
        iv  = 1'($urandom_range(0, 1));
        iw  = 1'($urandom_range(0, 1));
        ird = 4'($urandom_range(0, 15));
        rs1 = 4'($urandom_range(0, 15));
        rs2 = 4'($urandom_range(0, 15));
        stall_m = iv && (pend_m[rs1] || pend_m[rs2] || (iw && pend_m[ird]));
        if (av && bv)  winner = b_first ? 2 : 1;
        else if (av)   winner = 1;
        else if (bv)   winner = 2;
        else           winner = 0;
        // Scoreboard: retire the write on the port, then a new issue may set.
        if (exp_wr) pend_m[exp_rd] = 0;
        if (iv && iw && !stall_m) pend_m[ird] = 1;
        if (winner == 1) begin exp_wr = 1; exp_rd = ar; exp_di = ad; b_first = 1; end
        else if (winner == 2) begin exp_wr = 1; exp_rd = br; exp_di = bd; b_first = 0; end
        else exp_wr = 0;
        apply(mk(int'(av), int'(ar), ad, int'(bv), int'(br), bd,
                 int'(iv), int'(iw), int'(ird), int'(rs1), int'(rs2),
                 int'(winner == 1), int'(winner == 2), int'(stall_m),
                 int'(exp_wr), int'(exp_rd), exp_di, 0, 0, 0),
              $sformatf("rand%0d", c));
        if (winner == 1) av = 0;
        if (winner == 2) bv = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
